// File: rtl/snake_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | snake_pkg : shared types and constants for the snake game blocks |
// | Rev 1.0   : initial release                                      |
// +------------------------------------------------------------------+
package snake_pkg;

  typedef logic [15:0] score_t;

  localparam int unsigned c_max_score = 999;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_e;

  // Compare against the headroom first so the 16-bit sum can never wrap.
  function automatic score_t sat_add(input score_t a, input score_t inc, input score_t ceil);
    if ((inc >= ceil) || (a > (ceil - inc))) begin
      return ceil;
    end
    return a + inc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rise_detect.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rise_detect : registered rising-edge detector                    |
// | Rev 1.0     : initial release                                    |
// +------------------------------------------------------------------+
module rise_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic in,
  output logic pulse
);

  logic r_in;
  logic r_prev_low;
  logic r_armed;

  // r_armed keeps a level that is already high at reset release from
  // looking like an edge: a real edge needs a low sample taken after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in       <= 1'b0;
      r_prev_low <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_in       <= in;
      r_prev_low <= r_armed & ~r_in;
      r_armed    <= 1'b1;
    end
  end

  assign pulse = r_in & r_prev_low;

endmodule
`default_nettype wire

// File: rtl/score_tracker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | score_tracker : game score, high score and score display control |
// | Rev 1.0       : initial release                                  |
// +------------------------------------------------------------------+
module score_tracker
  import snake_pkg::*;
#(
  parameter int unsigned POINTS_PER_FOOD = 1,
  parameter int unsigned MAX_SCORE       = c_max_score,
  parameter int unsigned BLINK_CYCLES    = 25_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        new_game,
  input  logic        food_eaten,
  input  logic        game_over,
  output logic [15:0] score,
  output logic [15:0] high_score,
  output logic        new_record,
  output logic [15:0] disp_score,
  output logic [1:0]  state_o
);

  localparam score_t c_pts   = score_t'(POINTS_PER_FOOD);
  localparam score_t c_max   = score_t'(MAX_SCORE);
  localparam int     c_cnt_w = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_blink_last = c_cnt_w'(BLINK_CYCLES - 1);

  state_e               r_state;
  state_e               w_next_state;
  score_t               r_score;
  score_t               r_high;
  logic                 r_new_record;
  logic [c_cnt_w-1:0]   r_blink_cnt;
  logic                 r_phase;
  logic                 w_food_pulse;
  score_t               w_score_inc;

  rise_detect u_food_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .in      (food_eaten),
    .pulse   (w_food_pulse)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // new_game wins over game_over while playing.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (new_game) w_next_state = PLAY;
      PLAY:    if (!new_game && game_over) w_next_state = OVER;
      OVER:    if (new_game) w_next_state = PLAY;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    state_o    = r_state;
    disp_score = ((r_state == OVER) && r_phase) ? r_high : r_score;
  end

  // Food counted on the same edge as game_over is included in the final score.
  always_comb begin
    w_score_inc = w_food_pulse ? sat_add(r_score, c_pts, c_max) : r_score;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_score      <= '0;
      r_high       <= '0;
      r_new_record <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (new_game) r_score <= '0;
        end
        PLAY: begin
          if (new_game) begin
            r_score <= '0;
          end else begin
            r_score <= w_score_inc;
            if (game_over) begin
              r_new_record <= (w_score_inc > r_high);
              if (w_score_inc > r_high) r_high <= w_score_inc;
            end
          end
        end
        OVER: begin
          if (new_game) begin
            r_score      <= '0;
            r_new_record <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Held at zero outside OVER so every game-over starts on the score phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (r_state != OVER) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (r_blink_cnt == c_blink_last) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  assign score      = r_score;
  assign high_score = r_high;
  assign new_record = r_new_record;

endmodule
`default_nettype wire
